// File: rtl/elevator_pkg.sv
// Shared elevator constants, enums and helpers used by the call request
// register and its per-button debounce cells.
package elevator_pkg;

    localparam int DEFAULT_LEVELS   = 32'sd8;
    localparam int DEFAULT_DEBOUNCE = 32'sd4;

    typedef enum logic [1:0] {
        BTN_IN   = 2'd0,
        BTN_UP   = 2'd1,
        BTN_DOWN = 2'd2
    } btn_group;

    // Ceiling log2, returns 0 for values of 1 or less.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button input: 2-FF synchroniser, saturating hold counter and a single
// press pulse on the cycle the counter reaches DEBOUNCE.
module btn_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic a_reset,
    input  logic raw,
    output logic pulse
);

    localparam int CW = (clog2(DEBOUNCE + 1) < 1) ? 1 : clog2(DEBOUNCE + 1);

    logic          meta_r;
    logic          sync_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;

    // Synchroniser and hold counter state.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            cnt_r  <= '0;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
            cnt_r  <= cnt_s;
        end
    end

    // Counter saturates at DEBOUNCE so a long hold produces exactly one pulse.
    always_comb begin
        cnt_s = cnt_r;
        if (!sync_r) begin
            cnt_s = '0;
        end else if (cnt_r != CW'(DEBOUNCE)) begin
            cnt_s = cnt_r + CW'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    assign pulse = sync_r && (cnt_r == CW'(DEBOUNCE - 1));

endmodule

// File: rtl/call_request_register.sv
// Elevator call latch: debounces all buttons, latches calls until cleared and
// registers direction summaries. Optional toggle cancel: CALL_CANCEL_EN.
module call_request_register
    import elevator_pkg::*;
#(
    parameter int LEVELS   = DEFAULT_LEVELS,
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE,
    parameter int LEVEL_W  = clog2(LEVELS),
    parameter int CNT_W    = clog2(3 * LEVELS - 1)
) (
    input  logic               clk,
    input  logic               a_reset,
    input  logic               buttons_block,
    input  logic [LEVELS-1:0]  btn_in,
    input  logic [LEVELS-2:0]  btn_up_out,
    input  logic [LEVELS-1:1]  btn_down_out,
    input  logic [LEVELS-1:0]  inactivate_in_levels,
    input  logic [LEVELS-2:0]  inactivate_out_up_levels,
    input  logic [LEVELS-1:1]  inactivate_out_down_levels,
    input  logic [LEVEL_W-1:0] current_level,
    output logic [LEVELS-1:0]  active_in_levels,
    output logic [LEVELS-2:0]  active_out_up_levels,
    output logic [LEVELS-1:1]  active_out_down_levels,
    output logic               req_above,
    output logic               req_below,
    output logic               req_here,
    output logic [CNT_W-1:0]   pending_count
);

    localparam int NBITS = 3 * LEVELS - 2;

    logic [LEVELS-1:0] in_pulse_s;
    logic [LEVELS-2:0] up_pulse_s;
    logic [LEVELS-1:1] down_pulse_s;
    logic [LEVELS-1:0] in_next_s;
    logic [LEVELS-2:0] up_next_s;
    logic [LEVELS-1:1] down_next_s;
    logic [LEVELS-1:0] calls_s;
    logic [NBITS-1:0]  all_s;
    logic              above_s;
    logic              below_s;
    logic              here_s;
    logic [CNT_W-1:0]  count_s;

    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_in
        btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk(clk), .a_reset(a_reset), .raw(btn_in[gi]), .pulse(in_pulse_s[gi])
        );
    end

    for (genvar gu = 0; gu < LEVELS - 1; gu++) begin : g_up
        btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk(clk), .a_reset(a_reset), .raw(btn_up_out[gu]), .pulse(up_pulse_s[gu])
        );
    end

    for (genvar gd = 1; gd < LEVELS; gd++) begin : g_down
        btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk(clk), .a_reset(a_reset), .raw(btn_down_out[gd]), .pulse(down_pulse_s[gd])
        );
    end

    // Latch next state: a clear always beats a press in the same cycle.
    always_comb begin
        in_next_s   = active_in_levels;
        up_next_s   = active_out_up_levels;
        down_next_s = active_out_down_levels;
        if (buttons_block) begin
            in_next_s   = active_in_levels & ~inactivate_in_levels;
            up_next_s   = active_out_up_levels & ~inactivate_out_up_levels;
            down_next_s = active_out_down_levels & ~inactivate_out_down_levels;
        end else begin
`ifdef CALL_CANCEL_EN
            in_next_s = (active_in_levels ^ in_pulse_s) & ~inactivate_in_levels;
`else
            in_next_s = (active_in_levels | in_pulse_s) & ~inactivate_in_levels;
`endif
            up_next_s   = (active_out_up_levels | up_pulse_s) & ~inactivate_out_up_levels;
            down_next_s = (active_out_down_levels | down_pulse_s) & ~inactivate_out_down_levels;
        end
    end

    // Summaries; a level beyond the top floor leaves every call "below".
    always_comb begin
        calls_s               = active_in_levels;
        calls_s[LEVELS-2:0]   = calls_s[LEVELS-2:0] | active_out_up_levels;
        calls_s[LEVELS-1:1]   = calls_s[LEVELS-1:1] | active_out_down_levels;
        all_s                 = {active_out_down_levels, active_out_up_levels, active_in_levels};
        above_s               = 1'b0;
        below_s               = 1'b0;
        here_s                = 1'b0;
        count_s               = '0;
        for (int i = 0; i < LEVELS; i++) begin
            if (!calls_s[i]) begin
                above_s = above_s;
            end else if (i > int'(current_level)) begin
                above_s = 1'b1;
            end else if (i < int'(current_level)) begin
                below_s = 1'b1;
            end else begin
                here_s = 1'b1;
            end
        end
        for (int j = 0; j < NBITS; j++) begin
            count_s = count_s + CNT_W'(all_s[j]);
        end
    end

    // Call latches and registered summaries.
    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            active_in_levels       <= '0;
            active_out_up_levels   <= '0;
            active_out_down_levels <= '0;
            req_above              <= 1'b0;
            req_below              <= 1'b0;
            req_here               <= 1'b0;
            pending_count          <= '0;
        end else begin
            active_in_levels       <= in_next_s;
            active_out_up_levels   <= up_next_s;
            active_out_down_levels <= down_next_s;
            req_above              <= above_s;
            req_below              <= below_s;
            req_here               <= here_s;
            pending_count          <= count_s;
        end
    end

endmodule

// File: doc/call_request_register.md
Name: call_request_register

Overview:
Clocked, parametrised successor to the elevator call-button latch. Synchronises and debounces all in-car and hall buttons for LEVELS floors, then latches each call until the controller clears it. Derives registered direction summaries (above/below/here) and a pending-call count relative to the car's current level. Sits between the raw button inputs and the elevator motion controller.

Parameters:
LEVELS, 8, number of floors; minimum 2.
DEBOUNCE, 4, consecutive synchronised-high cycles needed to accept a press; minimum 1.
LEVEL_W, $clog2(LEVELS), width of current_level.
CNT_W, $clog2(3*LEVELS-1), width of pending_count.

Ports:
clk  in  1  system clock, all logic on rising edge.
a_reset  in  1  reset; asynchronous, active-high.
buttons_block  in  1  1 = new presses are ignored; existing calls are kept.
btn_in  in  LEVELS [LEVELS-1:0]  in-car floor buttons, raw/asynchronous.
btn_up_out  in  LEVELS-1 [LEVELS-2:0]  hall up buttons, raw.
btn_down_out  in  LEVELS-1 [LEVELS-1:1]  hall down buttons, raw.
inactivate_in_levels  in  LEVELS  synchronous clear of in-car calls.
inactivate_out_up_levels  in  LEVELS-1 [LEVELS-2:0]  clear of hall up calls.
inactivate_out_down_levels  in  LEVELS-1 [LEVELS-1:1]  clear of hall down calls.
current_level  in  LEVEL_W  car position, synchronous to clk.
active_in_levels  out  LEVELS  latched in-car calls.
active_out_up_levels  out  LEVELS-1 [LEVELS-2:0]  latched hall up calls.
active_out_down_levels  out  LEVELS-1 [LEVELS-1:1]  latched hall down calls.
req_above  out  1  any active call at a level greater than current_level.
req_below  out  1  any active call at a level less than current_level.
req_here  out  1  any active call at current_level.
pending_count  out  CNT_W  popcount of all active bits.

Behaviour:
- Reset: all active_* = 0, req_* = 0, pending_count = 0, synchronisers and debounce counters = 0. Reset mid-debounce discards the press in progress.
- Per button: 2-FF synchroniser, then a saturating counter 0..DEBOUNCE. Counter increments while the synchronised input is 1 and is forced to 0 when it is 0.
- A press pulse fires only on the cycle the counter goes from DEBOUNCE-1 to DEBOUNCE. One pulse per hold; the button must be released before it can fire again.
- The active bit is set on the pulse edge. Latency from a stable raw high to active = 2+DEBOUNCE cycles (6 at default). A pulse shorter than DEBOUNCE cycles after synchronisation is ignored.
- The pulse is suppressed if buttons_block = 1 in the pulse cycle. A press already in progress when the block is released does not re-fire until the button is released and pressed again.
- inactivate_* clears the matching active bit on the next edge. Clear wins over a simultaneous set.
- Holding a button while its inactivate is asserted leaves the call clear; no re-latch occurs without release.
- Summaries: req_above, req_below, req_here and pending_count are registered from the current active_* and current_level, so they lag an active change by one cycle. A level's call = in OR up OR down at that index.
- current_level >= LEVELS: req_above = 0, req_here = 0, req_below = any active.
- pending_count counts at most 3*LEVELS-2 bits and cannot overflow.

Optional Feature:
CALL_CANCEL_EN
- Defined: a new accepted press on an in-car button whose active_in_levels bit is already 1 clears that bit (toggle cancel). Hall buttons are unaffected. inactivate still has priority; buttons_block still suppresses the press.
- Undefined: a re-press of an active call has no effect.

Decomposition:
- Shared package elevator_pkg holds:
  - DEFAULT_LEVELS and DEFAULT_DEBOUNCE constants;
  - clog2 helper function;
  - btn_group enum (BTN_IN, BTN_UP, BTN_DOWN), for bench reporting.
- Sub-module btn_debounce (synchroniser, counter, pulse output), instantiated 3*LEVELS-2 times via generate. The top level holds the latches, clear logic and summary registers.

Test Plan:
- Reset then a btn_in[3] stable pulse of 10 cycles (DEBOUNCE=4) -> active_in_levels[3] rises exactly 6 cycles after input rise; pending_count = 1 one cycle later; stays latched after release.
- btn_up_out[2] high for 3 cycles only -> no active change, pending_count stays 0.
- active_in_levels[5] and active_out_down_levels[1] set, current_level = 3 -> req_above = 1, req_below = 1, req_here = 0. Then current_level = 5 -> req_here = 1, req_above = 0.
- Simultaneous press pulse and inactivate_out_up_levels[0] -> active_out_up_levels[0] stays 0. Separately, inactivate_in_levels[5] for one cycle -> bit clears the next edge and pending_count decrements one cycle after that.
- buttons_block = 1 while btn_in[7] and btn_down_out[6] are held 10 cycles -> no new calls; existing calls kept. After block release with buttons still held -> still no new calls until release and re-press.
- CALL_CANCEL_EN defined, active_in_levels[2] = 1, btn_in[2] pressed again -> bit clears at 2+DEBOUNCE. Without the macro -> bit stays 1. Mid-debounce a_reset pulse -> all outputs 0 immediately; no late latch.
